// File: rtl/h_gen_array.sv
// Array of unary/stochastic bit-stream generators: each channel turns an IWID-bit
// activation into a 2**IWID-beat stream whose ones count equals the activation value.
module h_gen_array #(
    parameter int IDIM = 16,
    parameter int IWID = 8,
    parameter int ODIM = IDIM
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDIM*IWID-1:0] iData,
    input  logic                 iValid,
    output logic                 iReady,
    output logic [ODIM-1:0]      oBit,
    output logic                 oValid,
    output logic                 oLast,
    input  logic                 oReady
);

    if (ODIM != IDIM) begin : g_odim_check
        $error("h_gen_array: ODIM must equal IDIM");
    end

    localparam logic [IWID-1:0] CNT_LAST = '1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IWID-1:0] active [IDIM];
    logic [IWID-1:0] shadow [IDIM];
    logic            shadow_full;
    logic [IWID-1:0] cnt;
    logic [IWID-1:0] cnt_rev;

    logic accept;
    logic consume;
    logic final_beat;
    logic promote_shadow;
    logic load_direct;
    logic load_shadow;

    // Handshake decode; a vector arriving while the last beat leaves goes straight to active.
    always_comb begin
        iReady         = !shadow_full && !rst;
        oValid         = (state == STREAM) && !rst;
        oLast          = oValid && (cnt == CNT_LAST);
        accept         = iValid && iReady;
        consume        = oValid && oReady;
        final_beat     = consume && (cnt == CNT_LAST);
        promote_shadow = final_beat && shadow_full;
        load_direct    = accept && ((state == IDLE) || (final_beat && !shadow_full));
        load_shadow    = accept && !load_direct;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (final_beat && !shadow_full && !accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Buffers and beat counter; cnt wraps to 0 naturally after the final beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IDIM; i++) begin
                active[i] <= '0;
                shadow[i] <= '0;
            end
            shadow_full <= 1'b0;
            cnt         <= '0;
        end else begin
            if (promote_shadow) begin
                for (int i = 0; i < IDIM; i++) begin
                    active[i] <= shadow[i];
                end
                shadow_full <= 1'b0;
                cnt         <= '0;
            end else if (load_direct) begin
                for (int i = 0; i < IDIM; i++) begin
                    active[i] <= iData[i*IWID +: IWID];
                end
                cnt <= '0;
            end else if (consume) begin
                cnt <= cnt + 1'b1;
            end

            if (load_shadow) begin
                for (int i = 0; i < IDIM; i++) begin
                    shadow[i] <= iData[i*IWID +: IWID];
                end
                shadow_full <= 1'b1;
            end
        end
    end

    // Comparing against the bit-reversed count spreads each channel's ones evenly over the stream.
    always_comb begin
        cnt_rev = '0;
        for (int b = 0; b < IWID; b++) begin
            cnt_rev[b] = cnt[IWID-1-b];
        end
    end

    always_comb begin
        oBit = '0;
        for (int i = 0; i < ODIM; i++) begin
            oBit[i] = oValid && (active[i] > cnt_rev);
        end
    end

endmodule
